// File: rtl/stepped_core.sv
// -----------------------------------------------------------------------------
// stepped_core
// Multi-cycle demo processor. Each instruction is fetched from an external
// asynchronous-read ROM and walked through FETCH/DECODE/EXEC/WB, one state per
// prescaler tick. HALT parks the core in a terminal HALTED state.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   run           step enable; prescaler and FSM freeze while low
//   instruction   32-bit ROM word at `address` (combinational)
//   address       program counter
//   result        value of the last OUT instruction
//   result_valid  one-clock pulse when `result` is loaded
//   halted        high once HALT has executed, until reset
// -----------------------------------------------------------------------------
module stepped_core #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int REG_AW   = 4,
    parameter int PRESCALE = 30000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [31:0]       instruction,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              halted
);

    localparam int              NREGS   = 2 ** REG_AW;
    localparam int              CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_OUT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [31:0]        ir_q;
    logic [DATA_W-1:0]  a_q, b_q, y_q, y_d;
    logic               eq_q;
    logic [DATA_W-1:0]  result_q;
    logic               result_valid_q;
    logic               halted_q;
    logic [DATA_W-1:0]  regs_q [NREGS];

    // Instruction fields
    logic [3:0]         opcode;
    logic [REG_AW-1:0]  ra, rb, rd;
    logic [15:0]        imm;
    logic [DATA_W-1:0]  sext_imm;
    logic [DATA_W-1:0]  rd_a, rd_b;
    logic               tick;
    logic               writes_rd;

    assign opcode   = ir_q[31:28];
    assign ra       = ir_q[24 +: REG_AW];
    assign rb       = ir_q[20 +: REG_AW];
    assign rd       = ir_q[16 +: REG_AW];
    assign imm      = ir_q[15:0];
    assign sext_imm = DATA_W'(signed'(imm));

    // Register 0 is hard-wired to zero on the read side.
    assign rd_a = (ra == '0) ? '0 : regs_q[ra];
    assign rd_b = (rb == '0) ? '0 : regs_q[rb];

    assign tick      = run && !halted_q && (cnt_q == CNT_MAX);
    assign writes_rd = (opcode >= OP_ADDI) && (opcode <= OP_XOR);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        cnt_d = cnt_q;
        if (run && !halted_q) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        y_d = '0;
        unique case (opcode)
            OP_ADDI: y_d = a_q + sext_imm;
            OP_ADD:  y_d = a_q + b_q;
            OP_SUB:  y_d = a_q - b_q;
            OP_AND:  y_d = a_q & b_q;
            OP_OR:   y_d = a_q | b_q;
            OP_XOR:  y_d = a_q ^ b_q;
            default: y_d = '0;
        endcase
    end

    // The branch offset is sign-extended and then truncated to the PC width,
    // which is the same as adding its low ADDR_W bits modulo 2^ADDR_W.
    always_comb begin
        pc_d = pc_q + ADDR_W'(1);
        if (opcode == OP_BEQ && eq_q) begin
            pc_d = pc_q + imm[ADDR_W-1:0];
        end else if (opcode == OP_JMP) begin
            pc_d = imm[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_FETCH;
            cnt_q          <= '0;
            pc_q           <= '0;
            ir_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            y_q            <= '0;
            eq_q           <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            halted_q       <= 1'b0;
            // NOTE: the register file is small and architecturally defined to
            // clear on reset, so it is built from flops rather than a RAM.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            cnt_q          <= cnt_d;
            result_valid_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    S_FETCH: begin
                        ir_q    <= instruction;
                        state_q <= S_DECODE;
                    end
                    S_DECODE: begin
                        a_q     <= rd_a;
                        b_q     <= rd_b;
                        state_q <= S_EXEC;
                    end
                    S_EXEC: begin
                        y_q     <= y_d;
                        eq_q    <= (a_q == b_q);
                        state_q <= S_WB;
                    end
                    S_WB: begin
                        if (writes_rd && rd != '0) begin
                            regs_q[rd] <= y_q;
                        end
                        pc_q <= pc_d;
                        if (opcode == OP_OUT) begin
                            result_q       <= a_q;
                            result_valid_q <= 1'b1;
                        end
                        if (opcode == OP_HALT) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign address      = pc_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_stepped_core.sv
// -----------------------------------------------------------------------------
// tb_stepped_core
// Directed bench for stepped_core. Two instances share one clock: u1 steps
// every clock (PRESCALE=1), u4 steps every fourth clock (PRESCALE=4). Each has
// its own ROM array; expected values are hand-computed per program.
// -----------------------------------------------------------------------------
module tb_stepped_core;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance stepping every clock
    logic        rst1 = 1'b1;
    logic        run1 = 1'b1;
    logic [31:0] rom1 [8];
    logic [2:0]  address1;
    logic [31:0] result1;
    logic        valid1;
    logic        halted1;

    // Instance stepping every fourth clock
    logic        rst4 = 1'b1;
    logic        run4 = 1'b1;
    logic [31:0] rom4 [8];
    logic [2:0]  address4;
    logic [31:0] result4;
    logic        valid4;
    logic        halted4;

    stepped_core #(.DATA_W(32), .ADDR_W(3), .REG_AW(4), .PRESCALE(1)) u1 (
        .clk          (clk),
        .rst          (rst1),
        .run          (run1),
        .instruction  (rom1[address1]),
        .address      (address1),
        .result       (result1),
        .result_valid (valid1),
        .halted       (halted1)
    );

    stepped_core #(.DATA_W(32), .ADDR_W(3), .REG_AW(4), .PRESCALE(4)) u4 (
        .clk          (clk),
        .rst          (rst4),
        .run          (run4),
        .instruction  (rom4[address4]),
        .address      (address4),
        .result       (result4),
        .result_valid (valid4),
        .halted       (halted4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rd,
                                        input logic [15:0] imm);
        return {op, ra, rb, rd, imm};
    endfunction

    // Advance n rising edges and land 1 ns after the last one.
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom1();
        for (int i = 0; i < 8; i++) rom1[i] = 32'h0;
    endtask

    // Pulse reset between edges; the next edge is edge 1 after release.
    task automatic restart1();
        rst1 = 1'b1;
        #2;
        rst1 = 1'b0;
    endtask

    int bad;

    initial begin
        clear_rom1();
        for (int i = 0; i < 8; i++) rom4[i] = 32'h0;

        // ---------------- Reset state and arithmetic program ----------------
        rom1[0] = ins(4'h1, 4'd0, 4'd0, 4'd1, 16'd5);   // ADDI r1,r0,5
        rom1[1] = ins(4'h1, 4'd0, 4'd0, 4'd2, 16'd7);   // ADDI r2,r0,7
        rom1[2] = ins(4'h2, 4'd1, 4'd2, 4'd3, 16'd0);   // ADD r3,r1,r2
        rom1[3] = ins(4'hF, 4'd3, 4'd0, 4'd0, 16'd0);   // OUT r3

        clocks(2);
        check("reset_address", 64'(address1), 64'd0);
        check("reset_halted", 64'(halted1), 64'd0);
        rst1 = 1'b0;

        clocks(6);
        check("pre_reset_address", 64'(address1), 64'd1);
        rst1 = 1'b1;
        #1;
        check("async_reset_address", 64'(address1), 64'd0);
        check("async_reset_result", 64'(result1), 64'd0);
        check("async_reset_valid", 64'(valid1), 64'd0);
        check("async_reset_halted", 64'(halted1), 64'd0);
        rst1 = 1'b0;

        clocks(15);
        check("arith_valid_before", 64'(valid1), 64'd0);
        check("arith_result_before", 64'(result1), 64'd0);
        clocks(1);
        check("arith_result", 64'(result1), 64'd12);
        check("arith_valid", 64'(valid1), 64'd1);
        check("arith_address", 64'(address1), 64'd4);
        clocks(1);
        check("arith_valid_one_clock", 64'(valid1), 64'd0);

        // ---------------- Overflow and PC wrap ----------------
        clear_rom1();
        rom1[0] = ins(4'h1, 4'd0, 4'd0, 4'd1, 16'hFFFF); // ADDI r1,r0,-1
        rom1[1] = ins(4'h2, 4'd1, 4'd1, 4'd2, 16'd0);    // ADD r2,r1,r1
        rom1[2] = ins(4'hF, 4'd2, 4'd0, 4'd0, 16'd0);    // OUT r2
        restart1();
        clocks(12);
        check("overflow_result", 64'(result1), 64'hFFFF_FFFE);
        check("overflow_valid", 64'(valid1), 64'd1);
        clocks(16);
        check("wrap_address_7", 64'(address1), 64'd7);
        clocks(4);
        check("wrap_address_0", 64'(address1), 64'd0);

        // ---------------- Writes to r0 are discarded ----------------
        clear_rom1();
        rom1[0] = ins(4'h1, 4'd0, 4'd0, 4'd1, 16'd5);   // ADDI r1,r0,5
        rom1[1] = ins(4'hF, 4'd1, 4'd0, 4'd0, 16'd0);   // OUT r1
        rom1[2] = ins(4'h1, 4'd0, 4'd0, 4'd0, 16'd9);   // ADDI r0,r0,9
        rom1[3] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);   // OUT r0
        restart1();
        clocks(8);
        check("r0_setup_result", 64'(result1), 64'd5);
        clocks(8);
        check("r0_result", 64'(result1), 64'd0);
        check("r0_valid", 64'(valid1), 64'd1);

        // ---------------- Control flow: taken/untaken BEQ, JMP ----------------
        clear_rom1();
        rom1[1] = ins(4'h7, 4'd0, 4'd0, 4'd0, 16'd3);   // BEQ r0,r0,+3
        rom1[4] = ins(4'h8, 4'd0, 4'd0, 4'd0, 16'd6);   // JMP 6
        rom1[6] = ins(4'h1, 4'd0, 4'd0, 4'd1, 16'd1);   // ADDI r1,r0,1
        rom1[7] = ins(4'h7, 4'd1, 4'd0, 4'd0, 16'd3);   // BEQ r1,r0,+3 (not taken)
        restart1();
        clocks(4);
        check("nop_address", 64'(address1), 64'd1);
        clocks(4);
        check("beq_taken_address", 64'(address1), 64'd4);
        clocks(4);
        check("jmp_address", 64'(address1), 64'd6);
        clocks(4);
        check("addi_address", 64'(address1), 64'd7);
        clocks(4);
        check("beq_not_taken_address", 64'(address1), 64'd0);

        clear_rom1();
        rom1[0] = ins(4'h7, 4'd0, 4'd0, 4'd0, 16'hFFFF); // BEQ r0,r0,-1
        rom1[7] = ins(4'h7, 4'd0, 4'd0, 4'd0, 16'd0);    // BEQ r0,r0,0
        restart1();
        clocks(4);
        check("beq_backward_address", 64'(address1), 64'd7);
        clocks(8);
        check("beq_self_loop_address", 64'(address1), 64'd7);

        // ---------------- HALT ----------------
        // Load r1=3, jump back to 0, then swap the ROM before the next FETCH.
        clear_rom1();
        rom1[0] = ins(4'h1, 4'd0, 4'd0, 4'd1, 16'd3);   // ADDI r1,r0,3
        rom1[1] = ins(4'h8, 4'd0, 4'd0, 4'd0, 16'd0);   // JMP 0
        restart1();
        clocks(8);
        check("halt_setup_address", 64'(address1), 64'd0);
        clear_rom1();
        rom1[0] = ins(4'hF, 4'd1, 4'd0, 4'd0, 16'd0);   // OUT r1
        rom1[1] = ins(4'hE, 4'd0, 4'd0, 4'd0, 16'd0);   // HALT
        rom1[2] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);   // OUT r0
        clocks(4);
        check("halt_out_result", 64'(result1), 64'd3);
        check("halt_out_valid", 64'(valid1), 64'd1);
        clocks(3);
        check("halted_before_wb", 64'(halted1), 64'd0);
        clocks(1);
        check("halted_at_wb", 64'(halted1), 64'd1);
        check("halt_address", 64'(address1), 64'd2);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            clocks(1);
            if (valid1 !== 1'b0 || result1 !== 32'd3 || address1 !== 3'd2 || halted1 !== 1'b1)
                bad++;
        end
        check("halt_frozen_cycles_bad", 64'(bad), 64'd0);
        check("halt_final_result", 64'(result1), 64'd3);

        // ---------------- Prescaler and run suspension ----------------
        rom4[0] = ins(4'h1, 4'd0, 4'd0, 4'd1, 16'd42);  // ADDI r1,r0,42
        rom4[1] = ins(4'hF, 4'd1, 4'd0, 4'd0, 16'd0);   // OUT r1
        rst4 = 1'b0;
        clocks(5);                        // tick at run-high clock 4 -> DECODE
        run4 = 1'b0;
        clocks(10);
        check("pre_hold_address", 64'(address4), 64'd0);
        check("pre_hold_valid", 64'(valid4), 64'd0);
        run4 = 1'b1;
        clocks(11);                       // 16 run-high clocks
        check("pre_addi_wb_address", 64'(address4), 64'd1);
        clocks(15);                       // 31 run-high clocks
        check("pre_valid_before", 64'(valid4), 64'd0);
        clocks(1);                        // 32 run-high clocks
        check("pre_valid", 64'(valid4), 64'd1);
        check("pre_result", 64'(result4), 64'd42);
        check("pre_address", 64'(address4), 64'd2);
        clocks(1);
        check("pre_valid_one_clock", 64'(valid4), 64'd0);
        clocks(3);
        check("pre_valid_stays_low", 64'(valid4), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stepped_core.md
# stepped_core

Parametrised multi-cycle successor to the single-step demo processor. It fetches 32-bit instructions from an external asynchronous-read program ROM through `address`, runs each one through a four-state FETCH/DECODE/EXEC/WB machine, and holds an internal register file. A built-in prescaler lets the core step at a human-visible rate on the board, or at every clock in simulation. `OUT` results drive the board display path.

## Interface
- `DATA_W`, 32: datapath and register width; must be ≥16.
- `ADDR_W`, 3: program-address width; program depth is 2^ADDR_W.
- `REG_AW`, 4: register-address width; must be ≤4; 2^REG_AW registers.
- `PRESCALE`, 30000000: clocks per FSM step; 1 = step every clock.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  step enable; prescaler and FSM frozen while low.
- `instruction`  in  32  ROM word at `address`, combinational.
- `address`  out  ADDR_W  program counter.
- `result`  out  DATA_W  last `OUT` value.
- `result_valid`  out  1  one-clock pulse when `result` updates.
- `halted`  out  1  high after `HALT` executes, until reset.

## Operation
- Fields:
  - [31:28] opcode
  - [27:24] ra
  - [23:20] rb
  - [19:16] rd
  - [15:0] imm
  - Register fields use their low REG_AW bits.
- Opcodes; all others are NOP (PC+1 only):
  - 0x1 ADDI: rd = ra + sext(imm)
  - 0x2 ADD: rd = ra + rb
  - 0x3 SUB: rd = ra − rb
  - 0x4 AND
  - 0x5 OR
  - 0x6 XOR
  - 0x7 BEQ: if ra==rb, PC = PC + sext(imm)
  - 0x8 JMP: PC = imm[ADDR_W-1:0]
  - 0xE HALT
  - 0xF OUT: result = ra
- Register 0 always reads 0; writes to it are discarded. All registers reset to 0.
- Arithmetic is modulo 2^DATA_W with no flags. imm is sign-extended to DATA_W.
- PC arithmetic is modulo 2^ADDR_W: PC+1 wraps from 2^ADDR_W−1 to 0, and the branch target is truncated. BEQ with offset 0 loops on itself.
- Tick generation:
  - Prescaler counts 0..PRESCALE−1 only while `run`=1 and not halted.
  - A tick is the clock where count==PRESCALE−1; the count then wraps to 0.
  - The count holds its value while `run`=0.
- FSM advances one state per tick:
  - FETCH: latch `instruction` into IR.
  - DECODE: latch A=reg[ra], B=reg[rb].
  - EXEC: latch ALU result Y; latch branch condition A==B.
  - WB: write Y to rd for ALU ops; update PC; for OUT, load `result`=A and pulse `result_valid`; for HALT, go to HALTED, otherwise go to FETCH.
- HALTED is terminal: no ticks, PC/registers/result frozen, `halted`=1.
- Reset (asynchronous, any state) sets:
  - PC=0, state=FETCH, prescaler=0, IR/A/B/Y=0, all registers 0
  - `result`=0, `result_valid`=0, `halted`=0

## Timing
- Every instruction takes exactly 4 ticks; with PRESCALE=1 and `run` held high, that is 4 clocks.
- After `rst` falls, the first rising edge with `run`=1 and a tick performs FETCH of address 0.
- With PRESCALE=1, instruction n (0-based) completes WB on rising edge 4n+4 after reset release.
- `address`, `result`, register writes and `halted` all update on the WB edge.
- `result_valid` is high for exactly the one clock following the WB edge of OUT. It never lasts longer than one clock, regardless of PRESCALE.
- `address` is stable from the WB edge through the next FETCH, so the ROM has ≥1 clock to settle.
- Read-after-write: a register written in WB is visible to the next instruction's DECODE. No bypass is needed.
- `run` dropping mid-instruction suspends in the current state; resuming continues with no lost or repeated state.

## Test plan
- Reset: PRESCALE=1, run for 6 clocks, then pulse `rst` between edges. Required: `address`=0, `result`=0, `result_valid`=0 and `halted`=0 immediately, with no clock edge. Execution then restarts at address 0.
- Arithmetic program: ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; OUT r3. Required: `result`=12 and a single-clock `result_valid` at edge 16; `address`=4.
- Wrap and overflow, DATA_W=32:
  - ADDI r1,r0,0xFFFF; ADD r2,r1,r1; OUT r2 → `result`=0xFFFFFFFE.
  - Eight NOPs → `address` goes 7 → 0.
  - ADDI r0,r0,9; OUT r0 → `result`=0.
- Control flow:
  - BEQ r0,r0,+3 at address 1 → `address`=4.
  - BEQ r1,r0 with r1≠0 → `address`=PC+1.
  - BEQ at 0 with imm=0xFFFF → `address`=7.
  - JMP 6 → `address`=6.
- Prescaler/run: PRESCALE=4; ADDI then OUT; hold `run` low for 10 clocks mid-DECODE. Required: `result_valid` after exactly 32 run-high clocks, with no state change while `run` is low.
- HALT: OUT r1 (r1=3); HALT; OUT r0. Required: `halted`=1 at the HALT WB edge; `address` frozen at 2; `result` stays 3 for 100 further clocks; `result_valid` never pulses again.
